// File: rtl/rx_irq_coal.sv
// rx_irq_coal: per-channel rx interrupt coalescing with a round-robin
// arbiter that funnels every channel onto one send_irq/irq_ack handshake.
module rx_irq_coal #(
   parameter int NCH = 2,
   parameter int PW  = 64,
   parameter int CHW = 1,
   parameter int TW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*PW-1:0] hw_ptr,
   input  logic [NCH*PW-1:0] sw_ptr,
   input  logic [NCH-1:0]    hst_rdy,
   input  logic [NCH-1:0]    irq_en,
   input  logic [TW-1:0]     timeout,
   input  logic [7:0]        thresh,
   output logic              send_irq,
   output logic [CHW-1:0]    irq_ch,
   input  logic              irq_ack,
   output logic [31:0]       irq_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_COAL, S_REQ, S_WAIT} chState_t;
   typedef enum logic {A_IDLE, A_BUSY} arbState_t;

   chState_t         r_state  [NCH];
   logic [TW-1:0]    r_tmr    [NCH];
   logic [7:0]       r_evt    [NCH];
   logic [PW-1:0]    r_swSnap [NCH];
   logic [NCH*PW-1:0] r_hwPtrQ;

   arbState_t        r_arb;
   logic             r_sendIrq;
   logic [CHW-1:0]   r_irqCh;
   logic [CHW-1:0]   r_rr;
   logic [31:0]      r_irqCnt;

   logic [NCH-1:0]   w_pend;
   logic [NCH-1:0]   w_hwMoved;
   logic [NCH-1:0]   w_req;
   logic [NCH-1:0]   w_grant;
   logic             w_found;
   logic [CHW-1:0]   w_idx;
   logic [CHW-1:0]   w_cand;

   assign send_irq = r_sendIrq;
   assign irq_ch   = r_irqCh;
   assign irq_cnt  = r_irqCnt;

   // Per-channel status: work pending, hw pointer moved this cycle, request, grant+ack
   always_comb begin
      w_pend    = '0;
      w_hwMoved = '0;
      w_req     = '0;
      w_grant   = '0;
      for (int i = 0; i < NCH; i++) begin
         w_pend[i]    = hw_ptr[i*PW +: PW] != sw_ptr[i*PW +: PW];
         w_hwMoved[i] = hw_ptr[i*PW +: PW] != r_hwPtrQ[i*PW +: PW];
         w_req[i]     = r_state[i] == S_REQ;
         w_grant[i]   = (r_arb == A_BUSY) && irq_ack && (r_irqCh == CHW'(i));
      end
   end

   // Round-robin pick: first requesting channel after the last one served
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 1; k <= NCH; k++) begin
         w_cand = CHW'((int'(r_rr) + k) % NCH);
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   // Per-channel coalescing FSM with timer, hw-update counter and sw snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hwPtrQ <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_state[i]  <= S_IDLE;
            r_tmr[i]    <= '0;
            r_evt[i]    <= '0;
            r_swSnap[i] <= '0;
         end
      end else begin
         r_hwPtrQ <= hw_ptr;
         for (int i = 0; i < NCH; i++) begin
            case (r_state[i])
               S_IDLE: begin
                  if (irq_en[i] && hst_rdy[i] && w_pend[i]) begin
                     r_state[i] <= S_COAL;
                     r_tmr[i]   <= timeout;
                     r_evt[i]   <= '0;
                  end
               end
               S_COAL: begin
                  if (!w_pend[i] || !irq_en[i] || !hst_rdy[i]) begin
                     r_state[i] <= S_IDLE;
                  end else if ((r_tmr[i] == '0) ||
                               ((thresh != 8'd0) && (r_evt[i] >= thresh))) begin
                     r_state[i] <= S_REQ;
                  end else begin
                     r_tmr[i] <= r_tmr[i] - TW'(1);
                  end
                  if (w_hwMoved[i] && (r_evt[i] != 8'hFF)) begin
                     r_evt[i] <= r_evt[i] + 8'd1;
                  end
               end
               S_REQ: begin
                  if (w_grant[i]) begin
                     r_state[i]  <= S_WAIT;
                     r_swSnap[i] <= sw_ptr[i*PW +: PW];
                  end
               end
               S_WAIT: begin
                  if ((sw_ptr[i*PW +: PW] != r_swSnap[i]) || !w_pend[i]) begin
                     r_state[i] <= S_IDLE;
                  end
               end
               default: r_state[i] <= S_IDLE;
            endcase
         end
      end
   end

   // Arbiter: registers one request at a time and holds it until acknowledged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arb     <= A_IDLE;
         r_sendIrq <= 1'b0;
         r_irqCh   <= '0;
         r_rr      <= CHW'(NCH - 1);
         r_irqCnt  <= '0;
      end else begin
         case (r_arb)
            A_IDLE: begin
               if (w_found) begin
                  r_sendIrq <= 1'b1;
                  r_irqCh   <= w_idx;
                  r_arb     <= A_BUSY;
               end
            end
            A_BUSY: begin
               if (irq_ack) begin
                  r_sendIrq <= 1'b0;
                  r_rr      <= r_irqCh;
                  r_irqCnt  <= r_irqCnt + 32'd1;
                  r_arb     <= A_IDLE;
               end
            end
            default: r_arb <= A_IDLE;
         endcase
      end
   end

endmodule
